// File: rtl/dram_arbiter.sv
// dram_arbiter: four-client round-robin arbiter and command sequencer for the 256x8 dual-port RAM.
// Defining DRAM_ARB_STATS_EN adds a saturating collision counter output (coll_cnt).
module dram_arbiter #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      rvalid,
  output logic [4*DW-1:0] rdata,
  output logic            ram_w1,
  output logic [AW-1:0]   ram_addr1,
  output logic [DW-1:0]   ram_d1,
  output logic            ram_w2,
  output logic [AW-1:0]   ram_addr2,
  output logic [DW-1:0]   ram_d2,
  input  logic [DW-1:0]   ram_dout1,
  input  logic [DW-1:0]   ram_dout2
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [15:0]     coll_cnt
`endif
);

  logic          ptr1, ptr2;
  logic          has1, has2;
  logic          sel1, sel2;
  logic          cw1, cw2;
  logic [AW-1:0] ca1, ca2;
  logic [DW-1:0] cd1, cd2;
  logic          collide;
  logic          go1, go2;

  logic          p1_v_s1, p1_id_s1, p1_v_s2, p1_id_s2;
  logic          p2_v_s1, p2_id_s1, p2_v_s2, p2_id_s2;

  // The pointer only matters when both clients of a pair request; port 2 yields on a collision.
  always_comb begin
    has1    = req[0] | req[1];
    has2    = req[2] | req[3];
    sel1    = (req[0] & req[1]) ? ptr1 : req[1];
    sel2    = (req[2] & req[3]) ? ptr2 : req[3];
    cw1     = sel1 ? we[1] : we[0];
    cw2     = sel2 ? we[3] : we[2];
    ca1     = sel1 ? addr[AW +: AW] : addr[0 +: AW];
    ca2     = sel2 ? addr[3*AW +: AW] : addr[2*AW +: AW];
    cd1     = sel1 ? wdata[DW +: DW] : wdata[0 +: DW];
    cd2     = sel2 ? wdata[3*DW +: DW] : wdata[2*DW +: DW];
    collide = has1 & has2 & (ca1 == ca2) & (cw1 | cw2);
    go1     = rst_n & has1;
    go2     = rst_n & has2 & ~collide;
    gnt     = {go2 & sel2, go2 & ~sel2, go1 & sel1, go1 & ~sel1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr1      <= 1'b0;
      ram_w1    <= 1'b0;
      ram_addr1 <= '0;
      ram_d1    <= '0;
      p1_v_s1   <= 1'b0;
      p1_id_s1  <= 1'b0;
      p1_v_s2   <= 1'b0;
      p1_id_s2  <= 1'b0;
    end else begin
      if (go1) begin
        ptr1      <= ~sel1;
        ram_w1    <= cw1;
        ram_addr1 <= ca1;
        ram_d1    <= cd1;
      end else begin
        ram_w1    <= 1'b0;
      end
      p1_v_s1  <= go1 & ~cw1;
      p1_id_s1 <= sel1;
      p1_v_s2  <= p1_v_s1;
      p1_id_s2 <= p1_id_s1;
    end
  end

  // A stalled port 2 keeps its pointer so the same client wins again next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr2      <= 1'b0;
      ram_w2    <= 1'b0;
      ram_addr2 <= '0;
      ram_d2    <= '0;
      p2_v_s1   <= 1'b0;
      p2_id_s1  <= 1'b0;
      p2_v_s2   <= 1'b0;
      p2_id_s2  <= 1'b0;
    end else begin
      if (go2) begin
        ptr2      <= ~sel2;
        ram_w2    <= cw2;
        ram_addr2 <= ca2;
        ram_d2    <= cd2;
      end else begin
        ram_w2    <= 1'b0;
      end
      p2_v_s1  <= go2 & ~cw2;
      p2_id_s1 <= sel2;
      p2_v_s2  <= p2_v_s1;
      p2_id_s2 <= p2_id_s1;
    end
  end

  always_comb begin
    rvalid = {p2_v_s2 & p2_id_s2, p2_v_s2 & ~p2_id_s2,
              p1_v_s2 & p1_id_s2, p1_v_s2 & ~p1_id_s2};
    rdata  = {ram_dout2, ram_dout2, ram_dout1, ram_dout1};
  end

`ifdef DRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt <= '0;
    end else if (collide && coll_cnt != 16'hFFFF) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and randomized checks of dram_arbiter against a transaction-level model.
// Includes a behavioural RAM; checks coll_cnt when DRAM_ARB_STATS_EN is defined.
module tb_dram_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req, we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt, rvalid;
  logic [4*DW-1:0] rdata;
  logic            ram_w1, ram_w2;
  logic [AW-1:0]   ram_addr1, ram_addr2;
  logic [DW-1:0]   ram_d1, ram_d2, ram_dout1, ram_dout2;
`ifdef DRAM_ARB_STATS_EN
  logic [15:0]     coll_cnt;
`endif

  logic [DW-1:0] ram [256];

  always #5 clk = ~clk;

  dram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_w1(ram_w1), .ram_addr1(ram_addr1), .ram_d1(ram_d1),
    .ram_w2(ram_w2), .ram_addr2(ram_addr2), .ram_d2(ram_d2),
    .ram_dout1(ram_dout1), .ram_dout2(ram_dout2)
`ifdef DRAM_ARB_STATS_EN
    , .coll_cnt(coll_cnt)
`endif
  );

  // Dual-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_w1) ram[ram_addr1] <= ram_d1;
    if (ram_w2) ram[ram_addr2] <= ram_d2;
    ram_dout1 <= ram[ram_addr1];
    ram_dout2 <= ram[ram_addr2];
  end

  typedef struct {
    int       due;
    int       cl;
    bit [7:0] d;
    bit       chk;
  } rd_t;

  int       n_cmp = 0;
  int       n_err = 0;
  int       cyc = 0;
  bit       rand_on = 1'b0;
  bit       pref [2];
  bit [7:0] mmem [256];
  bit       known [256];
  rd_t      rq [$];
  bit       exp_w [2];
  bit [7:0] exp_a [2];
  bit [7:0] exp_d [2];
  int       exp_coll = 0;
  bit       pend [4];
  bit       hold [4];
  bit       p_we [4];
  bit [7:0] p_a [4];
  bit [7:0] p_d [4];
  bit [3:0] exp_gnt;
  bit       coll_now;
  logic [3:0] last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input int k, input bit w, input bit [7:0] a, input bit [7:0] d);
    pend[k] = 1'b1;
    p_we[k] = w;
    p_a[k]  = a;
    p_d[k]  = d;
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      req[k]            = pend[k];
      we[k]             = p_we[k];
      addr[k*AW +: AW]  = p_a[k];
      wdata[k*DW +: DW] = p_d[k];
    end
  endtask

  // Arbitration rules of the reference model, evaluated on pending requests.
  task automatic model_grant();
    int  cand [2];
    bit  has [2];
    for (int p = 0; p < 2; p++) begin
      has[p] = pend[2*p] || pend[2*p+1];
      if (pend[2*p] && pend[2*p+1]) cand[p] = 2*p + int'(pref[p]);
      else                          cand[p] = pend[2*p] ? 2*p : 2*p + 1;
    end
    coll_now = has[0] && has[1] && (p_a[cand[0]] == p_a[cand[1]]) &&
               (p_we[cand[0]] || p_we[cand[1]]);
    exp_gnt = '0;
    if (has[0])              exp_gnt[cand[0]] = 1'b1;
    if (has[1] && !coll_now) exp_gnt[cand[1]] = 1'b1;
  endtask

  // Reads see every write granted on an earlier edge; results appear two edges later.
  task automatic commit();
    exp_w = '{1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      if (exp_gnt[k]) begin
        exp_w[k/2]  = p_we[k];
        exp_a[k/2]  = p_a[k];
        exp_d[k/2]  = p_d[k];
        pref[k/2]   = (k % 2 == 0);
        if (!p_we[k]) rq.push_back('{cyc + 2, k, mmem[p_a[k]], known[p_a[k]]});
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (exp_gnt[k] && p_we[k]) begin
        mmem[p_a[k]]  = p_d[k];
        known[p_a[k]] = 1'b1;
      end
    end
    if (coll_now && exp_coll < 65535) exp_coll++;
    for (int k = 0; k < 4; k++) if (exp_gnt[k] && !hold[k]) pend[k] = 1'b0;
    cyc++;
  endtask

  task automatic check_outputs();
    logic [3:0] erv;
    erv = '0;
    foreach (rq[i]) begin
      if (rq[i].due == cyc) begin
        erv[rq[i].cl] = 1'b1;
        if (rq[i].chk)
          chk($sformatf("rdata%0d", rq[i].cl), 32'(rdata[rq[i].cl*DW +: DW]), 32'(rq[i].d));
      end
    end
    for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= cyc) rq.delete(i);
    chk("rvalid", 32'(rvalid), 32'(erv));
    chk("ram_w1", 32'(ram_w1), 32'(exp_w[0]));
    chk("ram_addr1", 32'(ram_addr1), 32'(exp_a[0]));
    chk("ram_d1", 32'(ram_d1), 32'(exp_d[0]));
    chk("ram_w2", 32'(ram_w2), 32'(exp_w[1]));
    chk("ram_addr2", 32'(ram_addr2), 32'(exp_a[1]));
    chk("ram_d2", 32'(ram_d2), 32'(exp_d[1]));
`ifdef DRAM_ARB_STATS_EN
    chk("coll_cnt", 32'(coll_cnt), 32'(exp_coll));
`endif
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    check_outputs();
    if (rand_on) begin
      for (int k = 0; k < 4; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0)
          issue(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
    end
    drive();
    #1;
    model_grant();
    last_gnt = gnt;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    drive();
    #1;
    pref     = '{1'b0, 1'b0};
    rq.delete();
    exp_w    = '{1'b0, 1'b0};
    exp_a    = '{8'd0, 8'd0};
    exp_d    = '{8'd0, 8'd0};
    exp_coll = 0;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_ram_w1", 32'(ram_w1), 32'(0));
    chk("rst_ram_w2", 32'(ram_w2), 32'(0));
    chk("rst_ram_addr", 32'({ram_addr1, ram_addr2}), 32'(0));
    chk("rst_ram_d", 32'({ram_d1, ram_d2}), 32'(0));
    repeat (n) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pend[k] = 1'b0;
      hold[k] = 1'b0;
    end
    drive();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bit busy;
    for (int i = 0; i < 30; i++) begin
      busy = (rq.size() != 0);
      for (int k = 0; k < 4; k++) busy |= pend[k];
      if (!busy) break;
      step();
    end
    busy = (rq.size() != 0);
    for (int k = 0; k < 4; k++) busy |= pend[k];
    chk("drain_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      pend[k] = 1'b0;
      hold[k] = 1'b0;
      p_we[k] = 1'b0;
      p_a[k]  = '0;
      p_d[k]  = '0;
    end
    for (int i = 0; i < 256; i++) begin
      mmem[i]  = '0;
      known[i] = 1'b0;
    end
    drive();
    @(negedge clk);
    do_reset(2);

    // Round-robin: clients 2 and 3 keep reading for six cycles.
    issue(2, 1'b0, 8'd2, 8'd0);
    issue(3, 1'b0, 8'd3, 8'd0);
    hold[2] = 1'b1;
    hold[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_order", 32'(last_gnt), (i % 2 == 0) ? 32'h4 : 32'h8);
    end
    hold[2] = 1'b0;
    hold[3] = 1'b0;
    pend[2] = 1'b0;
    pend[3] = 1'b0;
    drain();

    // Client 0 writes then reads back address 1.
    issue(0, 1'b1, 8'd1, 8'd1);
    step();
    chk("wr_gnt0", 32'(last_gnt), 32'h1);
    chk("wr_cmd", 32'(ram_w1), 32'(1));
    issue(0, 1'b0, 8'd1, 8'd0);
    step();
    step();
    chk("rd_rvalid0", 32'(rvalid), 32'h1);
    chk("rd_rdata0", 32'(rdata[7:0]), 32'(1));
    drain();

    // Write/write collision on address 4; port 2 finishes last.
    issue(0, 1'b1, 8'd4, 8'd5);
    issue(2, 1'b1, 8'd4, 8'd9);
    step();
    chk("coll_gnt", 32'(last_gnt), 32'h1);
    step();
    chk("coll_gnt_next", 32'(last_gnt), 32'h4);
`ifdef DRAM_ARB_STATS_EN
    chk("coll_cnt_one", 32'(coll_cnt), 32'(1));
`endif
    issue(1, 1'b0, 8'd4, 8'd0);
    step();
    step();
    step();
    chk("coll_readback", 32'(rdata[15:8]), 32'(9));
    drain();

    // Read/read to the same address is not a collision.
    issue(1, 1'b0, 8'd4, 8'd0);
    issue(3, 1'b0, 8'd4, 8'd0);
    step();
    chk("rdrd_gnt", 32'(last_gnt), 32'hA);
    drain();

    // All four clients write distinct addresses, then read them back rotated.
    for (int k = 0; k < 4; k++) issue(k, 1'b1, 8'(10 + k), 8'(8'hA0 + k));
    step();
    chk("wr4_first", 32'(last_gnt), 32'h5);
    step();
    chk("wr4_second", 32'(last_gnt), 32'hA);
    for (int k = 0; k < 4; k++) issue(k, 1'b0, 8'(10 + (k + 1) % 4), 8'd0);
    drain();

    // Reset while a read is in flight: its rvalid must never appear.
    issue(1, 1'b0, 8'd11, 8'd0);
    step();
    issue(0, 1'b1, 8'd20, 8'd7);
    do_reset(2);
    step();
    step();
    step();

    // Randomized traffic on a narrow address range to provoke collisions.
    rand_on = 1'b1;
    repeat (400) step();
    rand_on = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Four-client arbiter and sequencer for the 256 x 8 dual-port RAM (`dram`). Clients 0/1 share RAM port 1 and clients 2/3 share RAM port 2, each pair arbitrated round-robin over a req/gnt handshake. The block registers the winning command toward the RAM and returns read data with a per-client valid strobe. It resolves cross-port address collisions by stalling port 2.

## Interface
- `DW`, default 8: data width, matches the RAM word.
- `AW`, default 8: address width, matches the RAM depth of 256.
- `clk`  in  1  rising-edge clock, shared with the RAM.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-client request; held until granted.
- `we`  in  4  per-client write enable; 0 means read.
- `addr`  in  4*AW  client k address at bits [k*AW +: AW].
- `wdata`  in  4*DW  client k write data at bits [k*DW +: DW].
- `gnt`  out  4  combinational grant; the transfer occurs at the rising edge where `req[k]` and `gnt[k]` are both 1.
- `rvalid`  out  4  one-cycle read-data strobe per client.
- `rdata`  out  4*DW  client k read data at bits [k*DW +: DW].
- `ram_w1`, `ram_addr1`, `ram_d1`  out  1/AW/DW  RAM port 1 command.
- `ram_w2`, `ram_addr2`, `ram_d2`  out  1/AW/DW  RAM port 2 command.
- `ram_dout1`, `ram_dout2`  in  DW  RAM read data; updated at the edge the RAM samples a read.

## Operation
- **Per-port round-robin.** Each port has a 1-bit priority pointer.
  - Port 1 reset value favours client 0; port 2 reset value favours client 2.
  - If only one client of a pair requests, that client is the candidate.
  - If both request, the pointer's client is the candidate.
  - After a completed grant, the pointer moves to the other client of the pair.
  - A stalled port keeps its pointer unchanged.
- **Collision rule.**
  - A collision exists when both ports have candidates, their addresses are equal, and at least one of them is a write.
  - On a collision, port 1 is granted and port 2 receives no grant that cycle.
  - Read/read to the same address is not a collision; both ports are granted.
- **Grant rules.**
  - `gnt` is never asserted without the corresponding `req`.
  - At most one `gnt` bit is high per pair.
- **Command stage.**
  - On a grant edge, the port's `ram_addr`/`ram_d` load the client's address and data, and `ram_w` loads `we`.
  - On a non-grant edge, `ram_w` goes to 0 while `ram_addr` and `ram_d` hold their values.
- **Read return.**
  - A granted read sets a tag holding the client index and a valid bit, which travels two register stages.
  - The cycle the tag reaches stage 2, `rvalid[k]`=1 and `rdata[k]` = that port's `ram_dout`.
  - Idle cycles and writes produce no `rvalid`.
  - `rdata` of non-valid clients is don't-care; the implementation drives it with the port's `ram_dout`.

## Timing
- **Reset values.**
  - `gnt` = 0 while `rst_n` is low.
  - `ram_w1`/`ram_w2` = 0, `ram_addr*` = 0, `ram_d*` = 0.
  - `rvalid` = 0, pointers at their reset positions, read tags cleared.
- **Grant latency.** `gnt` is combinational from `req`, `we`, `addr` and the pointers in the same cycle, with zero wait when uncontended.
- **Write latency.** Grant at edge N, RAM command visible in cycle N+1, RAM writes at edge N+1.
- **Read latency.** Grant at edge N, RAM samples at edge N+1, `rvalid` high during cycle N+2 (two cycles after the grant edge).
- **Throughput.** One transfer per port per cycle. Back-to-back requests from both clients of a pair alternate every cycle.
- **Reset mid-operation.** In-flight read tags are discarded with no `rvalid`, and any queued RAM write command is deasserted immediately.
- **Same-cycle write then read.** A port-1 write and a port-2 read to the same address in one cycle is a collision; port 2 is granted on the next cycle and reads the new value.

## Configuration
- Macro: `DRAM_ARB_STATS_EN`.
- **Defined.**
  - Adds output `coll_cnt` [15:0], reset to 0.
  - Increments on every edge where the collision rule stalled port 2.
  - Saturates at 16'hFFFF.
- **Undefined.** The port and counter are absent; arbitration behaviour is identical.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream -> all outputs are at their reset values, and a read granted one cycle earlier yields no `rvalid`.
- **Write then read, single client.** Client 0 writes 8'd1 to addr 8'd1, then reads addr 8'd1 -> `ram_w1`=1 in the cycle after the write grant, and `rvalid[0]`=1 with `rdata[0]`=8'd1 two cycles after the read grant.
- **Round-robin alternation.** Clients 2 and 3 hold read requests for 6 cycles -> `gnt` alternates 2,3,2,3,2,3, and `rvalid` follows the same order delayed 2 cycles.
- **Write/write collision.** Client 0 writes 8'd5 to addr 8'd4 while client 2 writes 8'd9 to addr 8'd4 -> `gnt[0]`=1 and `gnt[2]`=0 that cycle; `gnt[2]`=1 next cycle; a final read of addr 8'd4 returns 8'd9. `coll_cnt`=1 if `DRAM_ARB_STATS_EN` is defined.
- **Read/read, same address.** Clients 1 and 3 read addr 8'd4 simultaneously -> both granted in the same cycle, with no stall and no count.
- **Simultaneous traffic on both ports.** All four clients request writes to distinct addresses 8'd10..8'd13 -> each port completes 2 writes in 2 cycles, and subsequent reads return the written values.
